// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: handshaked imem read at the current PC, holds the
// fetched word for decode, and computes the next PC (stall / sequential / branch / jump).
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        misaligned,
  output logic [1:0]  fsm_state
);

  // Handshakes: a fetch completes on any cycle with imem_req && imem_ready; an
  // instruction retires on any cycle with instr_valid && instr_accept. Neither
  // side may withdraw: imem_req holds until ready, instr_valid holds until accept.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc4;
  logic [31:0] target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      instr      <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      state <= state_next;
      if (state == FETCH && imem_ready) begin
        instr <= imem_rdata;
      end
      if (state_next == ERROR) begin
        misaligned <= 1'b1;
      end
    end
  end

  // Redirect priority: jump over taken branch over fall-through.
  always_comb begin
    pc4 = pc_in + 32'd4;
    if (jump) begin
      target = {pc4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      target = branch_target;
    end else begin
      target = pc4;
    end
  end

  // The PC register has no enable, so feeding pc_in back is how the PC stalls.
  always_comb begin
    state_next = state;
    pc_next    = pc_in;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: if (imem_ready) state_next = HOLD;
      HOLD: begin
        if (instr_accept) begin
          if (target[1:0] != 2'b00) begin
            state_next = ERROR;
          end else begin
            pc_next    = target;
            state_next = FETCH;
          end
        end
      end
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
    if (reset) begin
      pc_next = RESET_PC;
    end
  end

  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc_in;
  assign fsm_state   = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register closing the loop
// from pc_next back to pc_in.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        misaligned;
  logic [1:0]  fsm_state;

  logic        load_en;
  logic [31:0] load_val;
  logic [31:0] pc_q;

  int n_checks;
  int n_fail;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .misaligned   (misaligned),
    .fsm_state    (fsm_state)
  );

  // clock / reset and the PC register the block feeds
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pc_q <= 32'h0;
    else if (load_en) pc_q <= load_val;
    else              pc_q <= pc_next;
  end
  assign pc_in = pc_q;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_word(input logic [31:0] w);
    imem_ready = 1'b1;
    imem_rdata = w;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic accept(input logic j, input logic [25:0] ji, input logic b,
                        input logic [31:0] bt, input logic [31:0] exp_pc, input string tag);
    jump          = j;
    jump_index    = ji;
    branch_taken  = b;
    branch_target = bt;
    instr_accept  = 1'b1;
    #1;
    check(tag, pc_next, exp_pc);
    tick();
    instr_accept = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    load_en  = 1'b1;
    load_val = v;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    load_en = 1'b0;
    load_val = 32'h0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0;
    instr_accept = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    jump = 1'b0;
    jump_index = 26'h0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;

    // 1: reset / idle
    check("rst_pc_next", pc_next, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_state", {30'b0, fsm_state}, 32'd0);
    check("idle_req", {31'b0, imem_req}, 32'h0);
    tick();
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    check("first_instr", instr, 32'h0);
    imem_ready = 1'b0;

    // 2: sequential fetch with three wait states
    for (int i = 0; i < 3; i++) begin
      check("t2_wait_req", {31'b0, imem_req}, 32'h1);
      tick();
    end
    check("t2_last_req", {31'b0, imem_req}, 32'h1);
    fetch_word(32'h2008_0005);
    check("t2_valid", {31'b0, instr_valid}, 32'h1);
    check("t2_instr", instr, 32'h2008_0005);
    check("t2_req_low", {31'b0, imem_req}, 32'h0);
    accept(1'b0, 26'h0, 1'b0, 32'h0, 32'h4, "t2_pc_next");
    check("t2_addr", imem_addr, 32'h4);
    check("t2_valid_fall", {31'b0, instr_valid}, 32'h0);
    check("t2_instr_held", instr, 32'h2008_0005);

    // 3: decode stall at PC 8; accept/jump ignored while fetching
    instr_accept = 1'b1;
    jump = 1'b1;
    jump_index = 26'h3FF_FFFF;
    #1;
    check("t3_ignore_fetch", pc_next, 32'h4);
    instr_accept = 1'b0;
    jump = 1'b0;
    fetch_word(32'h1111_1111);
    accept(1'b0, 26'h0, 1'b0, 32'h0, 32'h8, "t3_to_8");
    fetch_word(32'h8C09_0000);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_pc", pc_next, 32'h8);
      check("t3_stall_valid", {31'b0, instr_valid}, 32'h1);
      check("t3_stall_instr", instr, 32'h8C09_0000);
      check("t3_stall_req", {31'b0, imem_req}, 32'h0);
      tick();
    end
    imem_ready = 1'b0;
    accept(1'b0, 26'h0, 1'b0, 32'h0, 32'hC, "t3_release");

    // 4: redirects
    load_pc(32'h1000_0010);
    check("t4_addr", imem_addr, 32'h1000_0010);
    fetch_word(32'h0800_0040);
    accept(1'b1, 26'h000_0040, 1'b1, 32'h20, 32'h1000_0100, "t4_jump_wins");
    check("t4_jump_addr", imem_addr, 32'h1000_0100);
    fetch_word(32'h1000_0003);
    accept(1'b0, 26'h0, 1'b1, 32'h20, 32'h20, "t4_branch");
    check("t4_branch_addr", imem_addr, 32'h20);

    // 5: wrap and misalignment
    load_pc(32'hFFFF_FFFC);
    fetch_word(32'h0000_0020);
    accept(1'b0, 26'h0, 1'b0, 32'h0, 32'h0, "t5_wrap");
    check("t5_wrap_addr", imem_addr, 32'h0);
    fetch_word(32'h1000_0007);
    check("t5_pre_misaligned", {31'b0, misaligned}, 32'h0);
    accept(1'b0, 26'h0, 1'b1, 32'h22, 32'h0, "t5_misaligned_pc");
    check("t5_misaligned", {31'b0, misaligned}, 32'h1);
    check("t5_state_error", {30'b0, fsm_state}, 32'd3);
    check("t5_valid", {31'b0, instr_valid}, 32'h0);
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_err_req", {31'b0, imem_req}, 32'h0);
      check("t5_err_sticky", {31'b0, misaligned}, 32'h1);
      check("t5_err_pc", pc_next, 32'h0);
      tick();
    end
    imem_ready = 1'b0;

    // 6: asynchronous reset mid-FETCH
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_clear_misaligned", {31'b0, misaligned}, 32'h0);
    tick();
    fetch_word(32'h1234_5678);
    accept(1'b0, 26'h0, 1'b0, 32'h0, 32'h4, "t6_adv");
    check("t6_fetch_req", {31'b0, imem_req}, 32'h1);
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_req", {31'b0, imem_req}, 32'h0);
    check("t6_async_valid", {31'b0, instr_valid}, 32'h0);
    check("t6_async_instr", instr, 32'h0);
    check("t6_async_state", {30'b0, fsm_state}, 32'd0);
    tick();
    imem_ready = 1'b0;
    reset = 1'b0;
    tick();
    check("t6_restart_req", {31'b0, imem_req}, 32'h1);
    check("t6_restart_addr", imem_addr, 32'h0);
    check("t6_dropped_ready", instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
